// File: rtl/sram_bus_master_if.sv
// Bundle of the core-side request/response handshake and the AHB-style
// bus signals used by sram_bus_master. The master modport is the view of
// the bus master itself. The slave modport is the view of whatever drives
// requests and answers the bus, which is the testbench here.
interface sram_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  HRDATA, HREADY, HRESP,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output HRDATA, HREADY, HRESP,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/sram_bus_master.sv
// Single-outstanding bus master. It turns core load/store requests into
// AHB-style transfers that have one address phase and one data phase.
// Misaligned requests are answered with an error and never reach the bus.
// A data phase that stalls too long is abandoned with an error.
module sram_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               HCLK,
    input logic               HRESET,
    sram_bus_master_if.master bus
);

    localparam logic [1:0]  IDLE          = 2'd0;
    localparam logic [1:0]  ADDR          = 2'd1;
    localparam logic [1:0]  DATA          = 2'd2;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [15:0] TIMEOUT_LIM   = 16'(TIMEOUT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [15:0] waitCnt_q, waitCnt_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        loadUnsigned_q, loadUnsigned_d;
    logic        rspValid_q, rspValid_d;
    logic        rspErr_q, rspErr_d;
    logic [31:0] rspRdata_q, rspRdata_d;

    // A request is misaligned if it is an odd halfword, a word not on a
    // 4-byte boundary, or uses the reserved size code.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addrLo[0];
            2'b10:   bad = (addrLo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Right-aligned store data is copied onto every byte lane it could occupy.
    function automatic logic [31:0] replicateLanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{wdata[7:0]}};
            2'b01:   r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Pick the addressed lane out of the read bus, then zero- or sign-extend it.
    function automatic logic [31:0] extractLoad(input logic [31:0] rdata, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Next-state logic for the IDLE/ADDR/DATA sequence and the one-cycle response pulse.
    always_comb begin
        state_d        = state_q;
        waitCnt_d      = waitCnt_q;
        htrans_d       = htrans_q;
        haddr_d        = haddr_q;
        hwrite_d       = hwrite_q;
        hsize_d        = hsize_q;
        hwdata_d       = hwdata_q;
        loadUnsigned_d = loadUnsigned_q;
        rspValid_d     = 1'b0;
        rspErr_d       = 1'b0;
        rspRdata_d     = 32'h0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (isMisaligned(bus.req_size, bus.req_addr[1:0])) begin
                        rspValid_d = 1'b1;
                        rspErr_d   = 1'b1;
                    end else begin
                        state_d        = ADDR;
                        htrans_d       = HTRANS_NONSEQ;
                        haddr_d        = bus.req_addr;
                        hwrite_d       = bus.req_write;
                        hsize_d        = {1'b0, bus.req_size};
                        hwdata_d       = bus.req_write ? replicateLanes(bus.req_size, bus.req_wdata) : 32'h0;
                        loadUnsigned_d = bus.req_unsigned;
                    end
                end
            end
            ADDR: begin
                state_d   = DATA;
                htrans_d  = HTRANS_IDLE;
                waitCnt_d = 16'h0;
            end
            DATA: begin
                if (waitCnt_q == TIMEOUT_LIM) begin
                    state_d    = IDLE;
                    rspValid_d = 1'b1;
                    rspErr_d   = 1'b1;
                end else if (bus.HREADY) begin
                    state_d    = IDLE;
                    rspValid_d = 1'b1;
                    rspErr_d   = bus.HRESP;
                    if (!bus.HRESP && !hwrite_q) begin
                        rspRdata_d = extractLoad(bus.HRDATA, haddr_q[1:0], hsize_q[1:0], loadUnsigned_q);
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 16'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears everything and drops any transfer that is in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q        <= IDLE;
            waitCnt_q      <= 16'h0;
            htrans_q       <= HTRANS_IDLE;
            haddr_q        <= 32'h0;
            hwrite_q       <= 1'b0;
            hsize_q        <= 3'h0;
            hwdata_q       <= 32'h0;
            loadUnsigned_q <= 1'b0;
            rspValid_q     <= 1'b0;
            rspErr_q       <= 1'b0;
            rspRdata_q     <= 32'h0;
        end else begin
            state_q        <= state_d;
            waitCnt_q      <= waitCnt_d;
            htrans_q       <= htrans_d;
            haddr_q        <= haddr_d;
            hwrite_q       <= hwrite_d;
            hsize_q        <= hsize_d;
            hwdata_q       <= hwdata_d;
            loadUnsigned_q <= loadUnsigned_d;
            rspValid_q     <= rspValid_d;
            rspErr_q       <= rspErr_d;
            rspRdata_q     <= rspRdata_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_err   = rspErr_q;
    assign bus.rsp_rdata = rspRdata_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HWDATA    = hwdata_q;

endmodule

// File: tb/tb_sram_bus_master.sv
// Testbench for sram_bus_master. Directed requests push their expected
// response into a scoreboard. A monitor pops and compares an entry each
// time rsp_valid is seen. Bus-side timing is checked inline.
module tb_sram_bus_master;

    logic HCLK;
    logic HRESET;
    int   testsRun;
    int   testsFailed;
    logic sawRspAtAccept;

    logic        expErrQ[$];
    logic [31:0] expDataQ[$];
    string       expNameQ[$];

    sram_bus_master_if bus ();

    sram_bus_master #(.TIMEOUT_CYCLES(4)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    // 10 ns clock.
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Absolute guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge HCLK) begin
        if (!HRESET && bus.rsp_valid === 1'b1) begin
            testsRun++;
            if (expErrQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_rsp: got err=%0b rdata=0x%08h, expected no response",
                         bus.rsp_err, bus.rsp_rdata);
            end else begin
                logic        e;
                logic [31:0] d;
                string       n;
                e = expErrQ.pop_front();
                d = expDataQ.pop_front();
                n = expNameQ.pop_front();
                if (bus.rsp_err !== e || bus.rsp_rdata !== d) begin
                    testsFailed++;
                    $display("[TB] FAIL %s: got err=%0b rdata=0x%08h, expected err=%0b rdata=0x%08h",
                             n, bus.rsp_err, bus.rsp_rdata, e, d);
                end
            end
        end
    end

    // Issue one request and hold it until it is accepted. The expectation is
    // queued at the accept point when track is set. After the accept the
    // request fields are scrambled so that the captured values are exercised.
    task automatic applyStimulus(input string name, input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                 input logic track, input logic expErr, input logic [31:0] expRdata);
        int n;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (bus.req_ready !== 1'b1 && n < 50);
        if (bus.req_ready !== 1'b1) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s_accept: got req_ready=%0b, expected 1 within 50 cycles", name, bus.req_ready);
        end
        sawRspAtAccept = bus.rsp_valid;
        if (track) begin
            expErrQ.push_back(expErr);
            expDataQ.push_back(expRdata);
            expNameQ.push_back(name);
        end
        @(posedge HCLK);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_write    = ~wr;
        bus.req_addr     = ~addr;
        bus.req_size     = ~size;
        bus.req_unsigned = ~uns;
        bus.req_wdata    = ~wdata;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (expErrQ.size() != 0 && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        if (expErrQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL rsp_timeout: got %0d pending responses, expected 0", expErrQ.size());
            expErrQ.delete();
            expDataQ.delete();
            expNameQ.delete();
        end
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        int lat;
        testsRun         = 0;
        testsFailed      = 0;
        sawRspAtAccept   = 1'b0;
        HRESET           = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0;
        bus.HRDATA       = 32'h0;
        bus.HREADY       = 1'b1;
        bus.HRESP        = 1'b0;

        // Reset state.
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checkOutput("reset_htrans",    32'(bus.HTRANS),    32'h0);
        checkOutput("reset_haddr",     bus.HADDR,          32'h0);
        checkOutput("reset_hwrite",    32'(bus.HWRITE),    32'h0);
        checkOutput("reset_hsize",     32'(bus.HSIZE),     32'h0);
        checkOutput("reset_hwdata",    bus.HWDATA,         32'h0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("reset_rsp_err",   32'(bus.rsp_err),   32'h0);
        checkOutput("reset_rsp_rdata", bus.rsp_rdata,      32'h0);
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge HCLK);
        #1;

        // Word store with cycle-exact phase checks.
        applyStimulus("word_store", 1'b1, 32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        @(negedge HCLK);
        checkOutput("ws_t1_htrans", 32'(bus.HTRANS), 32'h2);
        checkOutput("ws_t1_haddr",  bus.HADDR,       32'h0000_0100);
        checkOutput("ws_t1_hwrite", 32'(bus.HWRITE), 32'h1);
        checkOutput("ws_t1_hsize",  32'(bus.HSIZE),  32'h2);
        @(negedge HCLK);
        checkOutput("ws_t2_htrans", 32'(bus.HTRANS), 32'h0);
        checkOutput("ws_t2_hwdata", bus.HWDATA,      32'hDEAD_BEEF);
        @(negedge HCLK);
        checkOutput("ws_t3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        waitIdle();

        // Byte loads from lane 3, signed and then unsigned.
        bus.HRDATA = 32'h8011_2233;
        applyStimulus("byte_load_signed",   1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80);
        waitIdle();
        applyStimulus("byte_load_unsigned", 1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0080);
        waitIdle();

        // Half store: lane replication and HSIZE.
        applyStimulus("half_store", 1'b1, 32'h0000_0102, 2'b01, 1'b0, 32'h0000_ABCD, 1'b1, 1'b0, 32'h0);
        @(negedge HCLK);
        checkOutput("hs_hsize", 32'(bus.HSIZE), 32'h1);
        checkOutput("hs_haddr", bus.HADDR,      32'h0000_0102);
        @(negedge HCLK);
        checkOutput("hs_hwdata", bus.HWDATA, 32'hABCD_ABCD);
        waitIdle();

        // Byte store: the low byte lands on every lane.
        applyStimulus("byte_store", 1'b1, 32'h0000_0101, 2'b00, 1'b0, 32'h1234_565A, 1'b1, 1'b0, 32'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        checkOutput("bs_hwdata", bus.HWDATA, 32'h5A5A_5A5A);
        waitIdle();

        // Half and word loads.
        bus.HRDATA = 32'h9876_1234;
        applyStimulus("half_load_hi_signed",  1'b0, 32'h0000_0202, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_9876);
        waitIdle();
        applyStimulus("half_load_lo_unsigned", 1'b0, 32'h0000_0200, 2'b01, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_1234);
        waitIdle();
        bus.HRDATA = 32'hCAFE_F00D;
        applyStimulus("word_load", 1'b0, 32'h0000_0204, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D);
        waitIdle();

        // Misaligned requests never reach the bus.
        applyStimulus("misaligned_word", 1'b0, 32'h0000_0101, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        @(negedge HCLK);
        checkOutput("mis_t1_htrans", 32'(bus.HTRANS), 32'h0);
        @(negedge HCLK);
        checkOutput("mis_t2_htrans", 32'(bus.HTRANS), 32'h0);
        waitIdle();
        applyStimulus("misaligned_half", 1'b1, 32'h0000_0103, 2'b01, 1'b0, 32'h5555, 1'b1, 1'b1, 32'h0);
        waitIdle();
        applyStimulus("reserved_size", 1'b0, 32'h0000_0100, 2'b11, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        waitIdle();

        // Timeout: 4 wait states, then abandoned on the following cycle.
        bus.HREADY = 1'b0;
        applyStimulus("timeout", 1'b0, 32'h0000_0300, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        lat = 0;
        do begin
            @(negedge HCLK);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 40);
        checkOutput("timeout_latency", 32'(lat), 32'd7);
        bus.HREADY = 1'b1;
        waitIdle();

        // HRESP error on a load and on a store.
        bus.HRESP  = 1'b1;
        bus.HRDATA = 32'h1234_5678;
        applyStimulus("hresp_load",  1'b0, 32'h0000_0400, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        waitIdle();
        applyStimulus("hresp_store", 1'b1, 32'h0000_0404, 2'b10, 1'b0, 32'h1, 1'b1, 1'b1, 32'h0);
        waitIdle();
        bus.HRESP = 1'b0;

        // Reset during the data phase discards the transfer with no response.
        bus.HREADY = 1'b0;
        applyStimulus("reset_mid", 1'b0, 32'h0000_0500, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        checkOutput("rst_mid_htrans",    32'(bus.HTRANS),    32'h0);
        checkOutput("rst_mid_haddr",     bus.HADDR,          32'h0);
        checkOutput("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        checkOutput("rst_mid_req_ready", 32'(bus.req_ready), 32'h1);
        bus.HREADY = 1'b1;
        repeat (4) @(negedge HCLK);
        @(posedge HCLK);
        #1;

        // Back-to-back loads: the second one is accepted while the first response is shown.
        bus.HRDATA = 32'h1122_3344;
        applyStimulus("b2b_first",  1'b0, 32'h0000_0600, 2'b00, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0000_0044);
        applyStimulus("b2b_second", 1'b0, 32'h0000_0602, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_1122);
        checkOutput("b2b_accept_during_rsp", 32'(sawRspAtAccept), 32'h1);
        waitIdle();

        repeat (3) @(negedge HCLK);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sram_bus_master.md
SRAM_BUS_MASTER -- requirements
Module: sram_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of data-phase wait cycles (HREADY low) before the transfer is abandoned; legal range 1..65535.
REQ-002 HCLK  in  1  single clock; all state updates on its rising edge.
REQ-003 HRESET  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  core request present.
REQ-005 req_ready  out  1  master can accept a request this cycle.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_size  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is reserved and treated as misaligned.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 rsp_valid  out  1  one-cycle response pulse.
REQ-012 rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-013 rsp_err  out  1  valid with rsp_valid; signals misalignment, HRESP error or timeout.
REQ-014 HADDR  out  32 / HTRANS  out  2 / HWRITE  out  1 / HSIZE  out  3 / HWDATA  out  32  bus master outputs.
REQ-015 HRDATA  in  32 / HREADY  in  1 / HRESP  in  1  bus responder inputs.

Function
REQ-016 The FSM SHALL have three states: IDLE, ADDR and DATA; at most one transfer is outstanding.
REQ-017 req_ready SHALL equal (state==IDLE); a request is accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-018 An accepted request that is misaligned SHALL NOT reach the bus. Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size 11. The next cycle SHALL show rsp_valid=1, rsp_err=1, and the FSM stays in IDLE.
REQ-019 An accepted aligned request SHALL move the FSM to ADDR. The following outputs are registered:
  - HTRANS=NONSEQ (10)
  - HADDR=req_addr
  - HWRITE=req_write
  - HSIZE={1'b0,req_size}
REQ-020 In ADDR the FSM SHALL go to DATA after exactly one cycle; HTRANS returns to IDLE (00) in DATA.
REQ-021 In DATA, HWDATA SHALL hold the store data with lane replication: byte on all four lanes, half on both halfwords, word unchanged.
REQ-022 HWDATA SHALL be held stable for the whole of DATA.
REQ-023 In DATA with HREADY=1 and HRESP=0, the FSM SHALL return to IDLE. The next cycle SHALL show rsp_valid=1 and rsp_err=0.
REQ-024 For a load, rsp_rdata SHALL take the lane selected by HADDR[1:0] (byte) or HADDR[1] (half) from HRDATA, then extend it per req_unsigned.
REQ-025 In DATA with HREADY=1 and HRESP=1, the FSM SHALL return to IDLE with rsp_err=1 and rsp_rdata=0.
REQ-026 A wait counter SHALL increment on each DATA cycle with HREADY=0 and clear on entry to DATA.
REQ-027 When the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE. The response is rsp_valid=1, rsp_err=1; HREADY on that cycle is ignored.
REQ-028 rsp_valid SHALL be high for exactly one cycle per accepted request. req_ready is high in that same cycle, so a back-to-back request is accepted while the response is presented.
REQ-029 Latency SHALL be as follows, for accept at edge T with zero wait states:
  - address phase in cycle T+1
  - data phase in cycle T+2
  - rsp_valid in cycle T+3
  - each wait state adds one cycle
REQ-030 The request fields SHALL be captured at accept; later changes on req_* inputs SHALL NOT affect the transfer in flight.

Reset
REQ-031 HRESET=1 at an edge SHALL force the following, in any state including mid-transfer:
  - state=IDLE, wait counter=0
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0
  - rsp_valid=0, rsp_err=0, rsp_rdata=0
REQ-032 Reset SHALL discard an in-flight transfer with no response. req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 Word store: addr 0x100, wdata 0xDEADBEEF, HREADY=1 -> NONSEQ at T+1 with HADDR=0x100, HWRITE=1, HSIZE=010; HWDATA=0xDEADBEEF at T+2; rsp_valid=1, rsp_err=0 at T+3.
REQ-034 Signed byte load: addr 0x103, HRDATA=0x80112233 -> rsp_rdata=0xFFFFFF80. The same load with req_unsigned=1 -> rsp_rdata=0x00000080.
REQ-035 Half store: addr 0x102, wdata 0x0000ABCD -> HWDATA=0xABCDABCD and HSIZE=001.
REQ-036 Misaligned word load at 0x101 -> HTRANS stays 00 throughout; rsp_valid=1, rsp_err=1 the next cycle.
REQ-037 Hold HREADY=0 in DATA with TIMEOUT_CYCLES=4 -> rsp_err=1 after 4 wait cycles. Separately, HREADY=1 with HRESP=1 -> rsp_err=1, rsp_rdata=0.
REQ-038 Assert HRESET during DATA -> HTRANS=00, no rsp_valid, req_ready=1 in the cycle after reset deasserts. Then issue back-to-back loads -> the second load is accepted in the same cycle as the first response.
